// File: rtl/dmem_ctrl.sv
// RV32 data memory controller: byte/half/word loads and stores with a registered response.
// Optional DMEM_MISALIGN_EN adds a two-cycle SPLIT path for word-spanning accesses.
//
// state | meaning
// IDLE  | ready for a request; aligned/in-word accesses finish here
// SPLIT | second word of a spanning access (built only with DMEM_MISALIGN_EN)
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state, next_state;

  logic [31:0]      mem [DEPTH_WORDS];
  logic             accept;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [1:0]       off;
  logic [3:0]       size_mask;
  logic [7:0]       be_span;
  logic [63:0]      wdata_span, rdata_span;
  logic [31:0]      ld_raw;
  logic             illegal, misalign, err, go_split, wr_lo;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
      2'b01:   extend = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  assign accept  = req_valid & req_ready;
  assign off     = req_addr[1:0];
  assign idx     = req_addr[IDX_W+1:2];
  assign idx_nxt = idx + 1'b1;

  always_comb begin
    size_mask = 4'b0001;
    illegal   = 1'b0;
    case (req_func3)
      3'b000, 3'b100: size_mask = 4'b0001;
      3'b001, 3'b101: size_mask = 4'b0011;
      3'b010:         size_mask = 4'b1111;
      default:        illegal   = 1'b1;
    endcase
    if (req_we && req_func3[2]) illegal = 1'b1;
  end

  // Two-word view: lanes 7:4 belong to the following word.
  assign be_span    = {4'b0000, size_mask} << off;
  assign wdata_span = {32'h0, req_wdata} << {off, 3'b000};
  assign rdata_span = {mem[idx_nxt], mem[idx]};
  assign ld_raw     = 32'(rdata_span >> {off, 3'b000});
  assign misalign   = (size_mask[1] & off[0]) | (size_mask[3] & (off != 2'b00));

  logic unused_addr;
  assign unused_addr = ^req_addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_EN
  logic             spanning;
  logic [IDX_W-1:0] hold_idx;
  logic [1:0]       hold_off;
  logic [2:0]       hold_func3;
  logic             hold_we;
  logic [3:0]       hold_be;
  logic [31:0]      hold_wdata, hold_lo, merged;

  assign spanning = |be_span[7:4];
  assign err      = illegal;
  assign go_split = accept & spanning & ~illegal;
  assign merged   = 32'({mem[hold_idx], hold_lo} >> {hold_off, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_idx   <= '0;
      hold_off   <= '0;
      hold_func3 <= '0;
      hold_we    <= 1'b0;
      hold_be    <= '0;
      hold_wdata <= '0;
      hold_lo    <= '0;
    end else if (go_split) begin
      hold_idx   <= idx_nxt;
      hold_off   <= off;
      hold_func3 <= req_func3;
      hold_we    <= req_we;
      hold_be    <= be_span[7:4];
      hold_wdata <= wdata_span[63:32];
      hold_lo    <= mem[idx];
    end
  end
`else
  logic unused_span;
  assign err         = illegal | misalign;
  assign go_split    = 1'b0;
  assign unused_span = ^{wdata_span[63:32], be_span[7:4]};
`endif

  assign wr_lo = accept & req_we & ~err;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lo && be_span[i]) mem[idx][8*i +: 8] <= wdata_span[8*i +: 8];
`ifdef DMEM_MISALIGN_EN
      if (state == SPLIT && hold_we && hold_be[i]) mem[hold_idx][8*i +: 8] <= hold_wdata[8*i +: 8];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (state == IDLE && go_split) next_state = SPLIT;
  end

  always_comb begin
    req_ready = (state == IDLE) & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (accept && !go_split) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'h0 : extend(ld_raw, req_func3);
      end
`ifdef DMEM_MISALIGN_EN
      if (state == SPLIT) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= hold_we ? 32'h0 : extend(merged, hold_func3);
      end
`endif
    end
  end
endmodule
